// File: rtl/huffman_pkg.sv
// Shared encodings and defaults for the Huffman frame controller.
// Imported by the request interface and the controller top.
package huffman_pkg;

  localparam int DEFAULT_BIT_WIDTH = 7;
  localparam int FRAME_CNT_W       = 10;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_CLEAR      = 3'd1;
  localparam logic [2:0] ST_LOAD       = 3'd2;
  localparam logic [2:0] ST_GAP        = 3'd3;
  localparam logic [2:0] ST_WAIT_TABLE = 3'd4;
  localparam logic [2:0] ST_DONE       = 3'd5;

  typedef enum logic [2:0] {
    IDLE       = ST_IDLE,
    CLEAR      = ST_CLEAR,
    LOAD       = ST_LOAD,
    GAP        = ST_GAP,
    WAIT_TABLE = ST_WAIT_TABLE,
    DONE       = ST_DONE
  } state_t;

endpackage

// File: rtl/huffman_frame_ctrl_if.sv
// Two-channel symbol request bus: ch0 in the low data slice, ch1 in the high slice.
// master = symbol source, slave = frame controller.
interface huffman_frame_ctrl_if
  import huffman_pkg::*;
#(
  parameter int BIT_WIDTH = DEFAULT_BIT_WIDTH
);

  logic [1:0]                 req_valid;
  logic [2*(BIT_WIDTH+1)-1:0] req_data;
  logic [1:0]                 req_last;
  logic [1:0]                 req_ready;

  modport master (
    output req_valid,
    output req_data,
    output req_last,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_data,
    input  req_last,
    output req_ready
  );

endinterface

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter: a lone requester wins, a tie goes to the pointer channel.
// Purely combinational; the pointer lives in the caller.
module rr_arbiter_2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = ptr ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/huffman_frame_ctrl.sv
// Frame scheduler sharing one Huffman encoder between two symbol sources.
// Define HUFF_FRAME_STATS_EN to add the frame_count / err_count statistics outputs.
module huffman_frame_ctrl
  import huffman_pkg::*;
#(
  parameter int BIT_WIDTH      = DEFAULT_BIT_WIDTH,
  parameter int FRAME_LEN      = 100,
  parameter int CLEAR_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                   clock,
  input  logic                   rst,
  huffman_frame_ctrl_if.slave    req,
  output logic                   enc_rst,
  output logic [BIT_WIDTH:0]     enc_data,
  output logic                   enc_data_enable,
  input  logic                   enc_out_valid,
  input  logic                   enc_out_last,
  output logic                   grant_id,
  output logic                   busy,
  output logic                   frame_done,
  output logic [FRAME_CNT_W-1:0] frame_len,
  output logic                   gap_term,
  output logic                   timeout_err
`ifdef HUFF_FRAME_STATS_EN
  ,
  output logic [15:0]            frame_count,
  output logic [7:0]             err_count
`endif
);

  localparam int SW    = BIT_WIDTH + 1;
  localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int CLR_W = $clog2(CLEAR_CYCLES + 1);

  state_t                 state, state_n;
  logic                   ptr;
  logic [1:0]             gnt;
  logic [1:0]             ready_q;
  logic [FRAME_CNT_W-1:0] sym_cnt;
  logic [CLR_W-1:0]       clr_cnt;
  logic [TO_W-1:0]        wait_cnt;
  logic                   gap_seen;

  logic          sel_valid, sel_last, accept, load_end, bubble;
  logic          table_done, wait_expire, timeout_hit;
  logic [SW-1:0] sel_data;

  rr_arbiter_2 u_arb (
    .req (req.req_valid),
    .ptr (ptr),
    .gnt (gnt)
  );

  assign req.req_ready = ready_q;

  assign sel_valid   = req.req_valid[grant_id];
  assign sel_last    = req.req_last[grant_id];
  assign sel_data    = grant_id ? req.req_data[2*SW-1:SW] : req.req_data[SW-1:0];
  assign accept      = (state == LOAD) && sel_valid && ready_q[grant_id];
  // Length limit fires on the beat that brings the count to FRAME_LEN, so a
  // req_last on that same beat closes just this one frame.
  assign load_end    = accept && (sel_last || (sym_cnt == FRAME_CNT_W'(FRAME_LEN - 1)));
  assign bubble      = (state == LOAD) && !sel_valid && (sym_cnt != '0);
  assign table_done  = enc_out_valid && enc_out_last;
  assign wait_expire = (wait_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign timeout_hit = (state == WAIT_TABLE) && !table_done && wait_expire;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:       if (|req.req_valid) state_n = CLEAR;
      CLEAR:      if (clr_cnt == CLR_W'(CLEAR_CYCLES - 1)) state_n = LOAD;
      LOAD:       if (load_end || bubble) state_n = GAP;
      GAP:        state_n = WAIT_TABLE;
      WAIT_TABLE: if (table_done || wait_expire) state_n = DONE;
      DONE:       state_n = IDLE;
      default:    state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      enc_rst         <= 1'b1;
      enc_data        <= '0;
      enc_data_enable <= 1'b0;
      grant_id        <= 1'b0;
      busy            <= 1'b0;
      frame_done      <= 1'b0;
      frame_len       <= '0;
      gap_term        <= 1'b0;
      timeout_err     <= 1'b0;
      ready_q         <= 2'b00;
      ptr             <= 1'b0;
      sym_cnt         <= '0;
      clr_cnt         <= '0;
      wait_cnt        <= '0;
      gap_seen        <= 1'b0;
    end else begin
      enc_rst         <= (state_n == CLEAR);
      busy            <= (state_n != IDLE);
      ready_q         <= (state_n == LOAD) ? (grant_id ? 2'b10 : 2'b01) : 2'b00;
      enc_data_enable <= accept;
      timeout_err     <= timeout_hit;
      frame_done      <= (state == DONE);
      clr_cnt         <= (state == CLEAR) ? clr_cnt + 1'b1 : '0;
      wait_cnt        <= (state == WAIT_TABLE) ? wait_cnt + 1'b1 : '0;

      if (accept) begin
        enc_data <= sel_data;
        sym_cnt  <= sym_cnt + 1'b1;
      end
      if (bubble) gap_seen <= 1'b1;

      if ((state == IDLE) && (state_n == CLEAR)) begin
        grant_id <= (gnt == 2'b10);
        sym_cnt  <= '0;
        gap_seen <= 1'b0;
      end

      if (state == DONE) begin
        frame_len <= sym_cnt;
        gap_term  <= gap_seen;
        ptr       <= ~grant_id;
      end
    end
  end

`ifdef HUFF_FRAME_STATS_EN
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      frame_count <= '0;
      err_count   <= '0;
    end else begin
      if (state == DONE) frame_count <= frame_count + 1'b1;
      if (timeout_hit && (err_count != 8'hFF)) err_count <= err_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_huffman_frame_ctrl.sv
// Directed bench for huffman_frame_ctrl with a small encoder-table responder.
// Build with HUFF_FRAME_STATS_EN to also check the statistics counters.
module tb_huffman_frame_ctrl;
  import huffman_pkg::*;

  localparam int BW = 7;
  localparam int SW = BW + 1;
  localparam int FL = 100;
  localparam int CC = 2;
  localparam int TO = 16;

  logic       clock = 1'b0;
  logic       rst   = 1'b0;
  logic       enc_rst, enc_data_enable, grant_id, busy, frame_done, gap_term, timeout_err;
  logic [BW:0] enc_data;
  logic [FRAME_CNT_W-1:0] frame_len;
  logic       enc_out_valid = 1'b0;
  logic       enc_out_last  = 1'b0;
`ifdef HUFF_FRAME_STATS_EN
  logic [15:0] frame_count;
  logic [7:0]  err_count;
`endif

  huffman_frame_ctrl_if #(.BIT_WIDTH(BW)) intf ();

  huffman_frame_ctrl #(
    .BIT_WIDTH      (BW),
    .FRAME_LEN      (FL),
    .CLEAR_CYCLES   (CC),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock           (clock),
    .rst             (rst),
    .req             (intf),
    .enc_rst         (enc_rst),
    .enc_data        (enc_data),
    .enc_data_enable (enc_data_enable),
    .enc_out_valid   (enc_out_valid),
    .enc_out_last    (enc_out_last),
    .grant_id        (grant_id),
    .busy            (busy),
    .frame_done      (frame_done),
    .frame_len       (frame_len),
    .gap_term        (gap_term),
    .timeout_err     (timeout_err)
`ifdef HUFF_FRAME_STATS_EN
    ,
    .frame_count     (frame_count),
    .err_count       (err_count)
`endif
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Observation log, sampled on the falling edge.
  logic [7:0] sym_q[$];
  int         sym_cyc[$];
  logic       fd_grant[$];
  int         fd_len[$];
  logic       fd_gap[$];
  int         fd_cyc[$];
  int         clr_seen = 0;
  int         to_cnt   = 0;
  int         to_cyc   = 0;
  int         fall_cyc = 0;
  logic       mon_prev_en = 1'b0;

  always @(negedge clock) begin
    if (rst) begin
      if (enc_data_enable) begin
        sym_q.push_back(enc_data);
        sym_cyc.push_back(cyc);
      end
      if (enc_rst) clr_seen <= clr_seen + 1;
      if (frame_done) begin
        fd_grant.push_back(grant_id);
        fd_len.push_back(int'(frame_len));
        fd_gap.push_back(gap_term);
        fd_cyc.push_back(cyc);
      end
      if (timeout_err) begin
        to_cnt <= to_cnt + 1;
        to_cyc <= cyc;
      end
      if (mon_prev_en && !enc_data_enable) fall_cyc <= cyc;
    end
    mon_prev_en <= enc_data_enable;
  end

  // Encoder stand-in: presents the final table entry resp_delay cycles after enable falls (0 = never).
  int   resp_delay = 2;
  int   pend       = 0;
  logic rprev      = 1'b0;

  always @(negedge clock) begin
    if (enc_out_valid) begin
      enc_out_valid <= 1'b0;
      enc_out_last  <= 1'b0;
    end
    if (pend > 0) begin
      pend <= pend - 1;
      if (pend == 1) begin
        enc_out_valid <= 1'b1;
        enc_out_last  <= 1'b1;
      end
    end
    if (rst && rprev && !enc_data_enable && resp_delay > 0) pend <= resp_delay;
    rprev <= enc_data_enable;
  end

  task automatic drive(input int ch, input logic v, input logic [7:0] d, input logic l);
    intf.req_valid[ch]         = v;
    intf.req_data[ch*SW +: SW] = d;
    intf.req_last[ch]          = l;
  endtask

  task automatic stream(input int ch, input int n, input logic [7:0] base,
                        input logic last_on_final, input string tag);
    int i     = 0;
    int guard = 0;
    while (i < n && guard < 400) begin
      @(negedge clock);
      drive(ch, 1'b1, base + 8'(i), last_on_final && (i == n - 1));
      if (intf.req_ready[ch]) i++;
      guard++;
    end
    check(tag, i, n);
    @(negedge clock);
    drive(ch, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic wait_frames(input int target, input string tag);
    int guard = 0;
    while (fd_grant.size() < target && guard < 300) begin
      @(negedge clock);
      guard++;
    end
    repeat (2) @(negedge clock);
    check(tag, fd_grant.size(), target);
  endtask

  int reset_base = 0;

  task automatic do_reset();
    @(negedge clock);
    rst = 1'b0;
    repeat (3) @(negedge clock);
    #1 rst = 1'b1;
    reset_base = fd_grant.size();
  endtask

  initial begin
    int sb, fb, cb, tb0, seen, guard;
    intf.req_valid = 2'b00;
    intf.req_data  = '0;
    intf.req_last  = 2'b00;

    // Reset state
    repeat (2) @(negedge clock);
    check("rst_enc_rst",     enc_rst, 1);
    check("rst_busy",        busy, 0);
    check("rst_ready",       intf.req_ready, 0);
    check("rst_enable",      enc_data_enable, 0);
    check("rst_frame_done",  frame_done, 0);
    check("rst_frame_len",   frame_len, 0);
    check("rst_grant",       grant_id, 0);
    check("rst_timeout_err", timeout_err, 0);
    #1 rst = 1'b1;

    // Ch0 five symbols 0x41..0x45
    repeat (2) @(negedge clock);
    sb = sym_q.size(); fb = fd_grant.size(); cb = clr_seen;
    stream(0, 5, 8'h41, 1'b1, "t1_accepted");
    wait_frames(fb + 1, "t1_frames");
    check("t1_clear_cycles", clr_seen - cb, CC);
    check("t1_sym_count", sym_q.size() - sb, 5);
    for (int i = 0; i < 5; i++) check($sformatf("t1_sym%0d", i), sym_q[sb + i], 8'h41 + i);
    check("t1_contiguous", sym_cyc[sb + 4] - sym_cyc[sb], 4);
    check("t1_grant", fd_grant[fb], 0);
    check("t1_len",   fd_len[fb], 5);
    check("t1_gap",   fd_gap[fb], 0);

    // Both channels from reset: grants alternate 0,1,0
    do_reset();
    sb = sym_q.size(); fb = fd_grant.size();
    @(negedge clock);
    drive(0, 1'b1, 8'h10, 1'b1);
    drive(1, 1'b1, 8'h20, 1'b1);
    seen = 0; guard = 0;
    while (seen < 3 && guard < 300) begin
      @(negedge clock);
      if (frame_done) seen++;
      guard++;
    end
    drive(0, 1'b0, 8'h00, 1'b0);
    drive(1, 1'b0, 8'h00, 1'b0);
    repeat (2) @(negedge clock);
    check("t2_frames", seen, 3);
    check("t2_grant0", fd_grant[fb],     0);
    check("t2_grant1", fd_grant[fb + 1], 1);
    check("t2_grant2", fd_grant[fb + 2], 0);
    check("t2_sym0", sym_q[sb],     8'h10);
    check("t2_sym1", sym_q[sb + 1], 8'h20);
    check("t2_sym2", sym_q[sb + 2], 8'h10);
    check("t2_len1", fd_len[fb + 1], 1);

    // Ch1 120 symbols without last: FRAME_LEN split, then bubble-terminated remainder
    sb = sym_q.size(); fb = fd_grant.size();
    stream(1, 120, 8'h00, 1'b0, "t3_accepted");
    wait_frames(fb + 2, "t3_frames");
    check("t3_len_a",   fd_len[fb], FL);
    check("t3_grant_a", fd_grant[fb], 1);
    check("t3_gap_a",   fd_gap[fb], 0);
    check("t3_len_b",   fd_len[fb + 1], 20);
    check("t3_grant_b", fd_grant[fb + 1], 1);
    check("t3_gap_b",   fd_gap[fb + 1], 1);
    check("t3_sym99",   sym_q[sb + 99], 8'd99);
    check("t3_sym100",  sym_q[sb + 100], 8'd100);
    check("t3_101st_after_done", fd_cyc[fb] < sym_cyc[sb + 100], 1);
    check("t3_encoder_idle", (sym_cyc[sb + 100] - sym_cyc[sb + 99]) >= CC + 4, 1);

    // Ch0 three symbols, one-cycle bubble, then two more
    sb = sym_q.size(); fb = fd_grant.size();
    stream(0, 3, 8'h61, 1'b0, "t4_accepted_a");
    stream(0, 2, 8'h64, 1'b1, "t4_accepted_b");
    wait_frames(fb + 2, "t4_frames");
    check("t4_len_a", fd_len[fb], 3);
    check("t4_gap_a", fd_gap[fb], 1);
    check("t4_len_b", fd_len[fb + 1], 2);
    check("t4_gap_b", fd_gap[fb + 1], 0);
    check("t4_sym3",  sym_q[sb + 3], 8'h64);

    // No table end: timeout 16 cycles after WAIT_TABLE entry, then frame_done
    resp_delay = 0;
    fb = fd_grant.size(); tb0 = to_cnt;
    stream(0, 1, 8'h77, 1'b1, "t5_accepted");
    wait_frames(fb + 1, "t5_frames");
    check("t5_timeouts", to_cnt - tb0, 1);
    check("t5_timeout_cycle", to_cyc - fall_cyc, TO);
    check("t5_done_after_timeout", fd_cyc[fb] - to_cyc, 1);
    check("t5_len", fd_len[fb], 1);
`ifdef HUFF_FRAME_STATS_EN
    check("t5_err_count", err_count, 1);
    check("t5_frame_count", frame_count, fd_grant.size() - reset_base);
`endif

    // Table end on the last allowed cycle: completion wins
    resp_delay = TO - 1;
    fb = fd_grant.size();
    stream(0, 1, 8'h78, 1'b1, "t5b_accepted");
    wait_frames(fb + 1, "t5b_frames");
    check("t5b_no_timeout", to_cnt - tb0, 1);
    check("t5b_done_cycle", fd_cyc[fb] - fall_cyc, TO + 1);
`ifdef HUFF_FRAME_STATS_EN
    check("t5b_err_count", err_count, 1);
`endif
    resp_delay = 2;

    // Reset in the middle of LOAD
    sb = sym_q.size(); fb = fd_grant.size();
    @(negedge clock);
    drive(0, 1'b1, 8'h30, 1'b0);
    guard = 0;
    while (sym_q.size() < sb + 3 && guard < 60) begin
      @(negedge clock);
      guard++;
    end
    check("t6_reached_load", sym_q.size() >= sb + 3, 1);
    rst = 1'b0;
    #1;
    check("t6_enc_rst",   enc_rst, 1);
    check("t6_busy",      busy, 0);
    check("t6_ready",     intf.req_ready, 0);
    check("t6_enable",    enc_data_enable, 0);
    check("t6_frame_len", frame_len, 0);
    drive(0, 1'b0, 8'h00, 1'b0);
    repeat (2) @(negedge clock);
    #1 rst = 1'b1;
    repeat (30) @(negedge clock);
    check("t6_no_frame_done", fd_grant.size(), fb);
    check("t6_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
